// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types for the icache/dcache AXI-Lite arbiter
//
// Purpose: FSM state and ownership encodings used by axi_lite_arbiter and
// rr_arbiter2, plus a helper that names the opposite requester.
// Ports: none (package).

package axi_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2
    } arb_state_t;

    // Enum value doubles as the bit index into the request vector.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    function automatic arb_owner_t other_owner(input arb_owner_t o);
        return (o == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI-Lite channel bundle shared by caches and memory port
//
// Purpose: AR/R/AW/W/B signal group.
// Modports: master drives addresses/data/valids and response readies;
//           slave drives address/data readies and response valids/data.

interface axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rvalid, awready, wready, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin pick with completion-driven pointer
//
// Purpose: chooses between icache and dcache; on contention the one not
// granted last wins. The pointer moves only when a transaction completes.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   req[1:0]   - request per requester, indexed by arb_owner_t
//   advance    - pulse on transaction completion
//   winner_in  - owner of the transaction that is completing
//   grant      - combinational pick for the current request vector

module rr_arbiter2
    import axi_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    input  arb_owner_t winner_in,
    output arb_owner_t grant
);

    arb_owner_t ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= OWN_D;
        end else if (advance) begin
            ptr <= other_owner(winner_in);
        end
    end

    always_comb begin
        grant = ptr;
        if (req == 2'b01) begin
            grant = OWN_I;
        end else if (req == 2'b10) begin
            grant = OWN_D;
        end
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - per-transaction round-robin share of one AXI-Lite port
//
// Purpose: icache (read-only) and dcache (read/write) share m_axi. Ownership
// is granted for a whole transaction and held until its response handshake,
// so at most one transaction is outstanding downstream.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   s_icache  - icache port (AR/R only)
//   s_dcache  - dcache port (AR/R and AW/W/B)
//   m_axi     - shared downstream port
//   busy      - high while a transaction is granted

module axi_lite_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    axi_lite_if.slave    s_icache,
    axi_lite_if.slave    s_dcache,
    axi_lite_if.master   m_axi,
    output logic         busy
);

    arb_state_t state;
    arb_owner_t owner;
    arb_owner_t grant;
    logic       aw_done;
    logic       w_done;

    logic [1:0] req;
    logic       owner_rready;
    logic       rd_fire;
    logic       aw_fire;
    logic       w_fire;
    logic       b_fire;
    logic       advance;

    assign req[OWN_I] = s_icache.arvalid;
    assign req[OWN_D] = s_dcache.arvalid | s_dcache.awvalid;

    assign owner_rready = (owner == OWN_I) ? s_icache.rready : s_dcache.rready;

    assign rd_fire = (state == ARB_RD) && m_axi.rvalid && owner_rready;
    assign aw_fire = (state == ARB_WR) && !aw_done && s_dcache.awvalid && m_axi.awready;
    assign w_fire  = (state == ARB_WR) && !w_done  && s_dcache.wvalid  && m_axi.wready;
    assign b_fire  = (state == ARB_WR) && m_axi.bvalid && s_dcache.bready;
    assign advance = rd_fire | b_fire;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (advance),
        .winner_in (owner),
        .grant     (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB_IDLE;
            owner   <= OWN_D;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        owner <= grant;
                        busy  <= 1'b1;
                        // A dcache write outranks its own pending read.
                        if (grant == OWN_D && s_dcache.awvalid) begin
                            state <= ARB_WR;
                        end else begin
                            state <= ARB_RD;
                        end
                    end
                end
                ARB_RD: begin
                    if (rd_fire) begin
                        state <= ARB_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ARB_WR: begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                    if (b_fire) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= ARB_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Channel routing: everything not on the active channel is driven to 0.
    always_comb begin
        m_axi.araddr     = {ADDR_W{1'b0}};
        m_axi.arvalid    = 1'b0;
        m_axi.rready     = 1'b0;
        m_axi.awaddr     = {ADDR_W{1'b0}};
        m_axi.awvalid    = 1'b0;
        m_axi.wdata      = {DATA_W{1'b0}};
        m_axi.wstrb      = {(DATA_W/8){1'b0}};
        m_axi.wvalid     = 1'b0;
        m_axi.bready     = 1'b0;

        s_icache.arready = 1'b0;
        s_icache.rdata   = {DATA_W{1'b0}};
        s_icache.rvalid  = 1'b0;
        s_icache.awready = 1'b0;
        s_icache.wready  = 1'b0;
        s_icache.bvalid  = 1'b0;

        s_dcache.arready = 1'b0;
        s_dcache.rdata   = {DATA_W{1'b0}};
        s_dcache.rvalid  = 1'b0;
        s_dcache.awready = 1'b0;
        s_dcache.wready  = 1'b0;
        s_dcache.bvalid  = 1'b0;

        case (state)
            ARB_RD: begin
                if (owner == OWN_I) begin
                    m_axi.araddr     = s_icache.araddr;
                    m_axi.arvalid    = s_icache.arvalid;
                    m_axi.rready     = s_icache.rready;
                    s_icache.arready = m_axi.arready;
                    s_icache.rdata   = m_axi.rdata;
                    s_icache.rvalid  = m_axi.rvalid;
                end else begin
                    m_axi.araddr     = s_dcache.araddr;
                    m_axi.arvalid    = s_dcache.arvalid;
                    m_axi.rready     = s_dcache.rready;
                    s_dcache.arready = m_axi.arready;
                    s_dcache.rdata   = m_axi.rdata;
                    s_dcache.rvalid  = m_axi.rvalid;
                end
            end
            ARB_WR: begin
                if (!aw_done) begin
                    m_axi.awaddr     = s_dcache.awaddr;
                    m_axi.awvalid    = s_dcache.awvalid;
                    s_dcache.awready = m_axi.awready;
                end
                if (!w_done) begin
                    m_axi.wdata      = s_dcache.wdata;
                    m_axi.wstrb      = s_dcache.wstrb;
                    m_axi.wvalid     = s_dcache.wvalid;
                    s_dcache.wready  = m_axi.wready;
                end
                m_axi.bready    = s_dcache.bready;
                s_dcache.bvalid = m_axi.bvalid;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - self-checking bench for axi_lite_arbiter

module tb_axi_lite_arbiter;

    logic clk;
    logic rst;
    logic busy;

    int checks;
    int errors;

    // Reference round-robin pointer: 1 means dcache is favoured on contention.
    bit fav_d;

    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) ic ();
    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) dc ();
    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) mx ();

    axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_icache (ic),
        .s_dcache (dc),
        .m_axi    (mx),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic idle_drive();
        ic.araddr = '0; ic.arvalid = 0; ic.rready = 0; ic.awaddr = '0; ic.awvalid = 0;
        ic.wdata = '0; ic.wstrb = '0; ic.wvalid = 0; ic.bready = 0;
        dc.araddr = '0; dc.arvalid = 0; dc.rready = 0; dc.awaddr = '0; dc.awvalid = 0;
        dc.wdata = '0; dc.wstrb = '0; dc.wvalid = 0; dc.bready = 0;
        mx.arready = 0; mx.rdata = '0; mx.rvalid = 0; mx.awready = 0; mx.wready = 0; mx.bvalid = 0;
    endtask

    // One round: chosen requesters raise valids together from idle; a random
    // downstream slave answers; grant order and data are checked against the
    // round-robin rules. Tags: 1 icache read, 2 dcache read, 3 dcache write.
    task automatic run_round(input bit ri, input bit rdr, input bit rdw);
        logic [31:0] ia, dra, dwa, dwd, sra, exp_a;
        logic [3:0]  dws;
        logic [31:0] expq[$];
        int          expt[$];
        bit p_i, p_r, p_w, win_d;
        bit pi, pdr, pdw, pdwd, iw, drw, dbw, saw, sw, done;
        int rcnt, bcnt, act, cur, exp_t;
        logic [9:0] viol;

        ia  = 32'h1000_0000 | ($urandom & 32'h0000_fffc);
        dra = 32'h2000_0000 | ($urandom & 32'h0000_fffc);
        dwa = 32'h3000_0000 | ($urandom & 32'h0000_fffc);
        dwd = $urandom;
        dws = 4'($urandom_range(1, 15));

        p_i = ri; p_r = rdr; p_w = rdw;
        while (p_i || p_r || p_w) begin
            if (p_i && (p_r || p_w)) win_d = fav_d;
            else                     win_d = !p_i;
            if (!win_d) begin
                expq.push_back(ia);  expt.push_back(1); p_i = 0;
            end else if (p_w) begin
                expq.push_back(dwa); expt.push_back(3); p_w = 0;
            end else begin
                expq.push_back(dra); expt.push_back(2); p_r = 0;
            end
            fav_d = !win_d;
        end

        pi = ri; pdr = rdr; pdw = rdw; pdwd = rdw;
        iw = 0; drw = 0; dbw = 0; saw = 0; sw = 0; done = 0;
        rcnt = -1; bcnt = -1; act = 0; sra = '0;

        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            ic.arvalid = pi;  ic.araddr = ia;  ic.rready = 1'($urandom);
            dc.arvalid = pdr; dc.araddr = dra; dc.rready = 1'($urandom);
            dc.awvalid = pdw; dc.awaddr = dwa;
            dc.wvalid = pdwd; dc.wdata = dwd; dc.wstrb = dws; dc.bready = 1'($urandom);
            mx.arready = 1'($urandom); mx.awready = 1'($urandom); mx.wready = 1'($urandom);
            mx.rvalid = (rcnt == 0);
            mx.rdata  = (rcnt == 0) ? sra : 32'h0;
            mx.bvalid = (bcnt == 0);
            #1;

            cur = (act != 0) ? act : ((expt.size() != 0) ? expt[0] : 0);
            viol = {ic.arready & (cur != 1),
                    dc.arready & (cur != 2),
                    (dc.awready | dc.wready) & (cur != 3),
                    ic.rvalid & ~iw,
                    dc.rvalid & ~drw,
                    dc.bvalid & ~dbw,
                    mx.arvalid & (cur != 1) & (cur != 2),
                    (mx.awvalid | mx.wvalid) & (cur != 3),
                    (|ic.rdata) & ~iw,
                    (|dc.rdata) & ~drw};
            chk("isolation", viol, 0);

            if (mx.arvalid && mx.arready) begin
                if (expq.size() == 0) begin
                    chk("ar_unexpected", mx.araddr, 0);
                end else begin
                    exp_a = expq.pop_front(); exp_t = expt.pop_front();
                    chk("ar_order", mx.araddr, exp_a);
                    act = exp_t;
                end
                rcnt = $urandom_range(1, 3);
                sra  = rd_val(mx.araddr);
            end
            if (mx.awvalid && mx.awready) begin
                if (expq.size() == 0) begin
                    chk("aw_unexpected", mx.awaddr, 0);
                end else begin
                    exp_a = expq.pop_front(); exp_t = expt.pop_front();
                    chk("aw_order", mx.awaddr, exp_a);
                    act = exp_t;
                end
                saw = 1;
            end
            if (mx.wvalid && mx.wready) begin
                chk("w_payload", {mx.wstrb, mx.wdata}, {dws, dwd});
                sw = 1;
            end
            if (mx.rvalid && mx.rready) rcnt = -1;
            if (mx.bvalid && mx.bready) bcnt = -1;
            if (saw && sw) begin
                bcnt = $urandom_range(1, 3); saw = 0; sw = 0;
            end

            if (ic.arvalid && ic.arready) begin pi = 0; iw = 1; end
            if (ic.rvalid && ic.rready) begin
                chk("i_rdata", ic.rdata, rd_val(ia)); iw = 0; act = 0;
            end
            if (dc.arvalid && dc.arready) begin pdr = 0; drw = 1; end
            if (dc.rvalid && dc.rready) begin
                chk("d_rdata", dc.rdata, rd_val(dra)); drw = 0; act = 0;
            end
            if (dc.awvalid && dc.awready) begin pdw = 0; dbw = 1; end
            if (dc.wvalid && dc.wready) pdwd = 0;
            if (dc.bvalid && dc.bready) begin dbw = 0; act = 0; end

            if (rcnt > 0) rcnt--;
            if (bcnt > 0) bcnt--;
            done = !(pi | pdr | pdw | pdwd | iw | drw | dbw) && (expq.size() == 0);
        end
        chk("round_done", done, 1);
        @(negedge clk);
        idle_drive();
        #1;
        chk("round_idle", busy, 0);
    endtask

    initial begin
        bit ri, rdr, rdw;
        checks = 0;
        errors = 0;
        idle_drive();
        rst = 1'b1;
        fav_d = 1'b1;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_m_valids", {mx.arvalid, mx.awvalid, mx.wvalid, mx.rready, mx.bready}, 0);
        chk("rst_m_payload", {mx.araddr, mx.awaddr}, 0);
        chk("rst_m_wdata", {mx.wdata, mx.wstrb}, 0);
        chk("rst_s_side", {ic.arready, ic.rvalid, dc.arready, dc.rvalid, dc.awready, dc.wready, dc.bvalid}, 0);
        @(negedge clk);
        rst = 1'b0;

        // icache-only read with fixed slave latencies
        @(negedge clk);
        ic.arvalid = 1; ic.araddr = 32'h100; ic.rready = 1; #1;
        chk("i_bubble", mx.arvalid, 0);
        @(negedge clk); #1;
        chk("i_araddr", mx.araddr, 32'h100);
        chk("i_arvalid", mx.arvalid, 1);
        chk("i_busy", busy, 1);
        @(negedge clk); mx.arready = 1; #1;
        chk("i_arready", ic.arready, 1);
        @(negedge clk); ic.arvalid = 0; mx.arready = 0; mx.rvalid = 1; mx.rdata = 32'h0011_2233; #1;
        chk("i_rvalid", ic.rvalid, 1);
        chk("i_rdata_dir", ic.rdata, 32'h0011_2233);
        chk("i_rvalid_not_d", dc.rvalid, 0);
        @(negedge clk); mx.rvalid = 0; mx.rdata = '0; #1;
        chk("i_back_idle", busy, 0);

        // Reset asserted mid-read
        @(negedge clk); ic.arvalid = 1; ic.araddr = 32'h180;
        @(negedge clk); #1;
        chk("mr_arvalid_pre", mx.arvalid, 1);
        #2; rst = 1'b1; #1;
        chk("mr_arvalid_rst", mx.arvalid, 0);
        chk("mr_busy_rst", busy, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        chk("mr_regrant", {mx.arvalid, mx.araddr}, {1'b1, 32'h180});
        mx.arready = 1;
        @(negedge clk); ic.arvalid = 0; mx.arready = 0; mx.rvalid = 1; mx.rdata = 32'hCAFE_0001; #1;
        chk("mr_rdata", ic.rdata, 32'hCAFE_0001);
        @(negedge clk); mx.rvalid = 0; mx.rdata = '0;
        fav_d = 1'b1;

        // dcache write, W accepted before AW; icache read held waiting
        @(negedge clk);
        dc.awvalid = 1; dc.awaddr = 32'h400; dc.wvalid = 1; dc.wdata = 32'hDEAD_BEEF;
        dc.wstrb = 4'hF; dc.bready = 1;
        ic.arvalid = 1; ic.araddr = 32'h500; ic.rready = 1;
        @(negedge clk); mx.wready = 1; #1;
        chk("wr_aw", {mx.awvalid, mx.awaddr}, {1'b1, 32'h400});
        chk("wr_w", {mx.wvalid, mx.wstrb, mx.wdata}, {1'b1, 4'hF, 32'hDEAD_BEEF});
        chk("wr_no_ar", mx.arvalid, 0);
        @(negedge clk); mx.wready = 0; #1;
        chk("wr_w_forced_low", mx.wvalid, 0);
        @(negedge clk); #1;
        chk("wr_aw_held", mx.awvalid, 1);
        @(negedge clk); mx.awready = 1; #1;
        chk("wr_dc_awready", dc.awready, 1);
        @(negedge clk); mx.awready = 0; dc.awvalid = 0; dc.wvalid = 0; mx.bvalid = 1; #1;
        chk("wr_aw_low", mx.awvalid, 0);
        chk("wr_b_dc", dc.bvalid, 1);
        chk("wr_b_not_i", {ic.rvalid, ic.arready, mx.arvalid}, 0);
        @(negedge clk); mx.bvalid = 0; dc.bready = 0; #1;
        chk("wr_idle", busy, 0);
        chk("wr_i_bubble", mx.arvalid, 0);
        @(negedge clk); #1;
        chk("wr_i_after_b", {mx.arvalid, mx.araddr}, {1'b1, 32'h500});
        mx.arready = 1;
        @(negedge clk); ic.arvalid = 0; mx.arready = 0; mx.rvalid = 1; mx.rdata = 32'h1234_5678; #1;
        chk("wr_i_rdata", ic.rdata, 32'h1234_5678);
        @(negedge clk); idle_drive();
        fav_d = 1'b1;

        // Contention and dcache read+write together, then random rounds
        run_round(1, 1, 0);
        run_round(1, 1, 0);
        run_round(0, 1, 1);
        run_round(1, 1, 1);
        for (int r = 0; r < 40; r++) begin
            do begin
                ri = 1'($urandom); rdr = 1'($urandom); rdw = 1'($urandom);
            end while (!(ri | rdr | rdw));
            run_round(ri, rdr, rdw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
